alu_regfile: RTL and testbench
==============================

ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data width of every register, matching the ALU a/b/f width.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of registers; a power of two, at least 2; address width AW = log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port rd_addr_a, input, AW, register index for ALU operand a.
REQ-006 The block SHALL have port rd_addr_b, input, AW, register index for ALU operand b.
REQ-007 The block SHALL have port a, output, WIDTH, registered operand a for the ALU.
REQ-008 The block SHALL have port b, output, WIDTH, registered operand b for the ALU.
REQ-009 The block SHALL have port wb_valid, input, 1, ALU writeback request.
REQ-010 The block SHALL have port wb_ready, output, 1, writeback accepted when wb_valid and wb_ready are both high.
REQ-011 The block SHALL have port wb_addr, input, AW, destination register index.
REQ-012 The block SHALL have port wb_data, input, WIDTH, ALU result f.
REQ-013 The block SHALL have port wb_ovf, input, 1, ALU ovf for this result.
REQ-014 The block SHALL have port wb_take_branch, input, 1, ALU take_branch for this result.
REQ-015 The block SHALL have port clr_status, input, 1, clears ovf_sticky.
REQ-016 The block SHALL have port ovf_sticky, output, 1, set by any accepted write carrying wb_ovf=1.
REQ-017 The block SHALL have port branch_pulse, output, 1, one-cycle pulse following an accepted write carrying wb_take_branch=1.

Function
REQ-018 The FSM SHALL have two states: INIT (sequential clear) and READY.
REQ-019 In INIT, one register per cycle SHALL be cleared to 0, index counter 0 to DEPTH-1; after clearing DEPTH-1 the FSM SHALL enter READY next cycle (DEPTH cycles in INIT after rst falls).
REQ-020 wb_ready SHALL be 0 in INIT and 1 in READY; wb_valid in INIT SHALL be ignored with no state change.
REQ-021 An accepted write SHALL update register wb_addr at the clock edge; writes to register 0 SHALL be discarded (register 0 reads 0 always).
REQ-022 a and b SHALL be registered reads: value of rd_addr_a/rd_addr_b registers sampled at edge N appears on a/b after edge N (1-cycle latency).
REQ-023 In INIT, a and b SHALL read 0.
REQ-024 Read and write to the same address on the same edge: behaviour per REQ-030/REQ-031.
REQ-025 ovf_sticky SHALL set on an accepted write with wb_ovf=1 and clear on clr_status=1; simultaneous set and clear SHALL leave it set.
REQ-026 branch_pulse SHALL be 1 for exactly the cycle after an accepted write with wb_take_branch=1, else 0; back-to-back such writes SHALL hold it high each following cycle.

Reset
REQ-027 rst=1 at any clock edge, including mid-INIT or mid-writeback, SHALL force state INIT, clear counter 0, a=0, b=0, ovf_sticky=0, branch_pulse=0, wb_ready=0; a concurrent write SHALL be dropped.
REQ-028 While rst is held, the FSM SHALL stay in INIT with counter held at 0; clearing begins on the first edge with rst=0.
REQ-029 Register contents SHALL be guaranteed 0 only after INIT completes.

Configuration
REQ-030 With macro ALU_REGFILE_BYPASS_EN defined, a read of an address being written by an accepted write on the same edge SHALL return wb_data (register 0 still returns 0).
REQ-031 Without ALU_REGFILE_BYPASS_EN, the same read SHALL return the pre-write contents; the new value is visible one cycle later.

Verification
REQ-032 rst high 3 cycles then low -> wb_ready 0 for exactly 8 cycles, then 1; a=b=0 throughout.
REQ-033 Write 16'h03DB to r1, 16'h02A6 to r2; rd_addr_a=1, rd_addr_b=2 -> next cycle a=16'h03DB, b=16'h02A6.
REQ-034 Write 16'h1234 to r0, read r0 -> a=16'h0000.
REQ-035 Write r3=16'h0007 and read r3 same edge -> a=16'h0007 with ALU_REGFILE_BYPASS_EN, old value 16'h0000 without; 16'h0007 the cycle after in both builds.
REQ-036 Accepted write with wb_ovf=1 (data 16'h4940), next cycle clr_status=1 with another wb_ovf=1 write -> ovf_sticky stays 1; clr_status alone next -> 0; write with wb_take_branch=1 -> branch_pulse high exactly one cycle.
REQ-037 rst asserted for one cycle mid-INIT (counter=4) and during a write in READY -> INIT restarts from 0, full 8-cycle wb_ready=0, write dropped, ovf_sticky=0.

Source files
------------

// File: rtl/alu_regfile.sv
// Register file feeding ALU operands a/b, with writeback, sticky overflow and a branch pulse.
// Define ALU_REGFILE_BYPASS_EN to forward same-edge writeback data to the read ports.
module alu_regfile #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             wb_ovf,
    input  logic             wb_take_branch,
    input  logic             clr_status,
    output logic             ovf_sticky,
    output logic             branch_pulse
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ovf_q, ovf_d;
    logic             br_q, br_d;
    logic             wb_acc;
    logic             wr_en;

    assign wb_ready     = (state_q == READY);
    assign wb_acc       = wb_valid && wb_ready;
    // Writes to register 0 are accepted (and still report status) but never stored.
    assign wr_en        = wb_acc && (wb_addr != '0);

    assign a            = a_q;
    assign b            = b_q;
    assign ovf_sticky   = ovf_q;
    assign branch_pulse = br_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = '0;
        b_d     = '0;
        br_d    = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: begin
                a_d  = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
                b_d  = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`ifdef ALU_REGFILE_BYPASS_EN
                if (wr_en && (wb_addr == rd_addr_a)) a_d = wb_data;
                if (wr_en && (wb_addr == rd_addr_b)) b_d = wb_data;
`endif
                br_d = wb_acc && wb_take_branch;
            end
            default: state_d = INIT;
        endcase
        // Set wins over a simultaneous clear.
        if (wb_acc && wb_ovf) ovf_d = 1'b1;
        else if (clr_status)  ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ovf_q   <= 1'b0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ovf_q   <= ovf_d;
            br_q    <= br_d;
        end
    end

    // Storage has no reset; INIT walks the array clearing one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT)
                regs_q[cnt_q] <= '0;
            else if (wr_en)
                regs_q[wb_addr] <= wb_data;
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile; expected values are hand-computed constants.
module tb_alu_regfile;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [AW-1:0]    rd_addr_a, rd_addr_b, wb_addr;
    logic [WIDTH-1:0] a, b, wb_data;
    logic             wb_valid, wb_ready, wb_ovf, wb_take_branch, clr_status;
    logic             ovf_sticky, branch_pulse;

    int n_chk = 0;
    int n_err = 0;

    alu_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .a(a), .b(b),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .wb_ovf(wb_ovf), .wb_take_branch(wb_take_branch),
        .clr_status(clr_status), .ovf_sticky(ovf_sticky), .branch_pulse(branch_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic v, input logic [AW-1:0] ad, input logic [WIDTH-1:0] d,
                      input logic ov, input logic br);
        wb_valid = v; wb_addr = ad; wb_data = d; wb_ovf = ov; wb_take_branch = br;
    endtask

    // Expects 8 cycles of wb_ready=0 with zero operands, starting the cycle rst falls.
    task automatic init_window(input string tag, input bit poke);
        for (int i = 0; i < DEPTH; i++) begin
            chk({tag, "_rdy0"}, wb_ready, 0);
            chk({tag, "_a0"}, a, 0);
            chk({tag, "_b0"}, b, 0);
            // A write to an already-cleared entry during INIT must be ignored.
            if (poke && i == 5) wb(1'b1, 3'd1, 16'hBEEF, 1'b1, 1'b1);
            else                wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
            tick();
        end
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        chk({tag, "_rdy1"}, wb_ready, 1);
    endtask

    initial begin
        logic [15:0] exp_byp;
        rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0; clr_status = 1'b0;
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy", wb_ready, 0);
            chk("rst_a", a, 0);
            chk("rst_b", b, 0);
            chk("rst_ovf", ovf_sticky, 0);
            chk("rst_br", branch_pulse, 0);
        end
        rst = 1'b0;
        init_window("init", 1'b1);
        chk("init_ovf", ovf_sticky, 0);
        chk("init_br", branch_pulse, 0);

        rd_addr_a = 3'd1; rd_addr_b = 3'd7;
        tick();
        chk("ign_r1", a, 0);
        chk("ign_r7", b, 0);

        // Basic write then read.
        wb(1'b1, 3'd1, 16'h03DB, 1'b0, 1'b0); tick();
        wb(1'b1, 3'd2, 16'h02A6, 1'b0, 1'b0); tick();
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        rd_addr_a = 3'd1; rd_addr_b = 3'd2;
        tick();
        chk("rd_r1", a, 16'h03DB);
        chk("rd_r2", b, 16'h02A6);

        // Register 0 stays zero, including on a same-edge read.
        wb(1'b1, 3'd0, 16'h1234, 1'b0, 1'b0);
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        tick();
        chk("r0_same", a, 0);
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("r0_a", a, 0);
        chk("r0_b", b, 0);

        // Same-edge read/write of r3.
`ifdef ALU_REGFILE_BYPASS_EN
        exp_byp = 16'h0007;
`else
        exp_byp = 16'h0000;
`endif
        wb(1'b1, 3'd3, 16'h0007, 1'b0, 1'b0);
        rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        tick();
        chk("byp_a", a, exp_byp);
        chk("byp_b", b, exp_byp);
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        tick();
        chk("byp_a_next", a, 16'h0007);
        chk("byp_b_next", b, 16'h0007);

        // Sticky overflow: set, set+clear, clear, write without ovf.
        wb(1'b1, 3'd4, 16'h4940, 1'b1, 1'b0); tick();
        chk("ovf_set", ovf_sticky, 1);
        clr_status = 1'b1;
        wb(1'b1, 3'd5, 16'h1111, 1'b1, 1'b0); tick();
        chk("ovf_setclr", ovf_sticky, 1);
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0); tick();
        chk("ovf_clr", ovf_sticky, 0);
        clr_status = 1'b0;
        wb(1'b1, 3'd5, 16'h2222, 1'b0, 1'b0); tick();
        chk("ovf_noset", ovf_sticky, 0);
        wb(1'b0, 3'd0, 16'h0000, 1'b1, 1'b0); tick();
        chk("ovf_novalid", ovf_sticky, 0);
        rd_addr_a = 3'd4; rd_addr_b = 3'd5;
        tick();
        chk("rd_r4", a, 16'h4940);
        chk("rd_r5", b, 16'h2222);

        // Branch pulse: single, ignored without valid, back-to-back.
        wb(1'b1, 3'd6, 16'h0001, 1'b0, 1'b1); tick();
        chk("br_pulse", branch_pulse, 1);
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b1); tick();
        chk("br_drop", branch_pulse, 0);
        tick();
        chk("br_novalid", branch_pulse, 0);
        wb(1'b1, 3'd6, 16'h0002, 1'b0, 1'b1); tick();
        chk("br_b2b_1", branch_pulse, 1);
        wb(1'b1, 3'd0, 16'h0003, 1'b0, 1'b1); tick();
        chk("br_b2b_2", branch_pulse, 1);
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0); tick();
        chk("br_b2b_end", branch_pulse, 0);

        // Reset during a write in READY: write dropped, status cleared.
        wb(1'b1, 3'd4, 16'hABCD, 1'b1, 1'b1);
        rd_addr_a = 3'd1; rd_addr_b = 3'd4;
        rst = 1'b1;
        tick();
        chk("rstw_rdy", wb_ready, 0);
        chk("rstw_a", a, 0);
        chk("rstw_b", b, 0);
        chk("rstw_ovf", ovf_sticky, 0);
        chk("rstw_br", branch_pulse, 0);
        rst = 1'b0;
        wb(1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rdy", wb_ready, 0);
        // Reset again with the clear counter at 4; INIT must restart fully.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_window("reinit", 1'b0);
        chk("reinit_ovf", ovf_sticky, 0);
        tick();
        chk("reinit_r1", a, 0);
        chk("reinit_r4", b, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
